// File: rtl/multisim_rw_mem.sv
// Parametrised single-port memory command handler.
// Accepts one read/write command at a time over a valid/ready channel and
// returns exactly one response per command over a second valid/ready channel.
// Writes are byte-strobed and commit at the accept edge. A programmable number
// of access wait states can be inserted between accept and response.
// Addresses at or beyond DEPTH are reported as errors and leave memory untouched.
module multisim_rw_mem #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int WAIT_CYC = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_vld,
  output logic                  cmd_rdy,
  input  logic                  cmd_rwb,
  input  logic [ADDR_W-1:0]     cmd_address,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_wstrb,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  rsp_err
);

  localparam int              NB      = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYC);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic [3:0]          cnt_r;
  logic [3:0]          cnt_nx_s;

  // Command fields captured at accept.
  logic [ADDR_W-1:0]   addr_r;
  logic                rwb_r;
  logic                err_r;

  // Registered outputs.
  logic                cmd_rdy_r;
  logic                rsp_vld_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_err_r;

  logic                accept_s;
  logic                in_range_s;
  logic                rsp_hs_s;
  logic                rsp_load_s;
  logic [DATA_W-1:0]   rsp_data_nx_s;

  // Storage; deliberately not reset so contents survive rst_n.
  logic [DATA_W-1:0]   mem_r [DEPTH];

  assign cmd_rdy  = cmd_rdy_r;
  assign rsp_vld  = rsp_vld_r;
  assign rsp_data = rsp_data_r;
  assign rsp_err  = rsp_err_r;

  // Handshake and range decode.
  always_comb begin
    accept_s   = cmd_vld && cmd_rdy_r;
    in_range_s = ({1'b0, cmd_address} < DEPTH_L);
    rsp_hs_s   = rsp_vld_r && rsp_rdy;
    // First RESP cycle: the response payload is loaded here, rsp_vld follows.
    rsp_load_s = (state_r == ST_RESP) && !rsp_vld_r;
  end

  // Response payload: read data only for in-range reads, zero otherwise.
  always_comb begin
    rsp_data_nx_s = {DATA_W{1'b0}};
    if (rwb_r && !err_r) begin
      rsp_data_nx_s = mem_r[addr_r];
    end else begin
      rsp_data_nx_s = {DATA_W{1'b0}};
    end
  end

  // Next-state logic for the command FSM and the wait-state counter.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        state_nx_s = ST_IDLE;
      end
      ST_IDLE: begin
        if (accept_s) begin
          cnt_nx_s   = 4'd0;
          state_nx_s = (WAIT_CYC > 0) ? ST_ACCESS : ST_RESP;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if ((cnt_r + 4'd1) == WAIT_L) begin
          state_nx_s = ST_RESP;
        end else begin
          cnt_nx_s   = cnt_r + 4'd1;
          state_nx_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_hs_s) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_RESP;
        end
      end
      default: begin
        state_nx_s = ST_INIT;
        cnt_nx_s   = 4'd0;
      end
    endcase
  end

  // State, captured command and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_INIT;
      cnt_r      <= 4'd0;
      addr_r     <= {ADDR_W{1'b0}};
      rwb_r      <= 1'b0;
      err_r      <= 1'b0;
      cmd_rdy_r  <= 1'b0;
      rsp_vld_r  <= 1'b0;
      rsp_data_r <= {DATA_W{1'b0}};
      rsp_err_r  <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      // Ready only while idle and not accepting; this forces one bubble per command.
      cmd_rdy_r <= (state_r == ST_IDLE) && !accept_s;
      // Valid stays up through a stall and drops on the handshake edge.
      rsp_vld_r <= (state_r == ST_RESP) && !rsp_hs_s;
      if (accept_s) begin
        addr_r <= cmd_address;
        rwb_r  <= cmd_rwb;
        err_r  <= !in_range_s;
      end
      if (rsp_load_s) begin
        rsp_data_r <= rsp_data_nx_s;
        rsp_err_r  <= err_r;
      end
    end
  end

  // Byte-strobed write committed at the accept edge, in-range only.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (accept_s && !cmd_rwb && in_range_s && cmd_wstrb[b]) begin
        mem_r[cmd_address][b*8 +: 8] <= cmd_wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_multisim_rw_mem.sv
// Directed bench for multisim_rw_mem using three configurations:
//   inst 0: 8-bit, 256 deep, no wait states
//   inst 1: 32-bit, 200 deep, no wait states
//   inst 2: 8-bit, 256 deep, 3 wait states
module tb_multisim_rw_mem;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        cmd_vld  [3];
  logic        cmd_rwb  [3];
  logic [7:0]  cmd_addr [3];
  logic [31:0] cmd_wdat [3];
  logic [3:0]  cmd_strb [3];
  logic        rsp_rdy  [3];

  logic        o_rdy  [3];
  logic        o_vld  [3];
  logic        o_err  [3];
  logic [31:0] o_data [3];

  logic [7:0]  a_data;
  logic [31:0] b_data;
  logic [7:0]  c_data;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multisim_rw_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYC(0)) u_a (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld[0]), .cmd_rdy(o_rdy[0]), .cmd_rwb(cmd_rwb[0]),
    .cmd_address(cmd_addr[0]), .cmd_wdata(cmd_wdat[0][7:0]), .cmd_wstrb(cmd_strb[0][0:0]),
    .rsp_vld(o_vld[0]), .rsp_rdy(rsp_rdy[0]), .rsp_data(a_data), .rsp_err(o_err[0])
  );

  multisim_rw_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(200), .WAIT_CYC(0)) u_b (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld[1]), .cmd_rdy(o_rdy[1]), .cmd_rwb(cmd_rwb[1]),
    .cmd_address(cmd_addr[1]), .cmd_wdata(cmd_wdat[1]), .cmd_wstrb(cmd_strb[1]),
    .rsp_vld(o_vld[1]), .rsp_rdy(rsp_rdy[1]), .rsp_data(b_data), .rsp_err(o_err[1])
  );

  multisim_rw_mem #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_CYC(3)) u_c (
    .clk(clk), .rst_n(rst_n),
    .cmd_vld(cmd_vld[2]), .cmd_rdy(o_rdy[2]), .cmd_rwb(cmd_rwb[2]),
    .cmd_address(cmd_addr[2]), .cmd_wdata(cmd_wdat[2][7:0]), .cmd_wstrb(cmd_strb[2][0:0]),
    .rsp_vld(o_vld[2]), .rsp_rdy(rsp_rdy[2]), .rsp_data(c_data), .rsp_err(o_err[2])
  );

  assign o_data[0] = {24'd0, a_data};
  assign o_data[1] = b_data;
  assign o_data[2] = {24'd0, c_data};

  // Called at a negedge: wait for cmd_rdy, present one command, accept on the next
  // posedge, return at the following negedge with the command fields scrambled.
  task automatic send(input int i, input logic rwb, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    int n;
    n = 0;
    while (o_rdy[i] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (o_rdy[i] !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout inst %0d: cmd_rdy=%b after %0d cycles, want 1", i, o_rdy[i], n);
    end
    cmd_vld[i]  = 1'b1;
    cmd_rwb[i]  = rwb;
    cmd_addr[i] = a;
    cmd_wdat[i] = d;
    cmd_strb[i] = s;
    @(posedge clk);
    @(negedge clk);
    cmd_vld[i]  = 1'b0;
    cmd_rwb[i]  = ~rwb;
    cmd_addr[i] = 8'hEE;
    cmd_wdat[i] = 32'hDEAD_BEEF;
    cmd_strb[i] = 4'hF;
  endtask

  // Counts negedges from the post-accept negedge until rsp_vld is seen (50 = timeout).
  task automatic wait_rsp(input int i, output int lat);
    lat = 0;
    while (o_vld[i] !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Full transaction with rsp_rdy held high; returns at the negedge after the handshake.
  task automatic xact(input int i, input logic rwb, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      output int lat, output logic [31:0] data, output logic err);
    rsp_rdy[i] = 1'b1;
    send(i, rwb, a, d, s);
    wait_rsp(i, lat);
    data = o_data[i];
    err  = o_err[i];
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (o_rdy[i] !== 1'b0 || o_vld[i] !== 1'b0 || o_data[i] !== 32'd0 || o_err[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_state inst %0d: rdy=%b vld=%b data=%h err=%b, want 0 0 0 0",
                 i, o_rdy[i], o_vld[i], o_data[i], o_err[i]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (o_rdy[i] !== 1'b0 || o_vld[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_cycle1 inst %0d: rdy=%b vld=%b, want 0 0", i, o_rdy[i], o_vld[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (o_rdy[i] !== 1'b1 || o_vld[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_cycle2 inst %0d: rdy=%b vld=%b, want 1 0", i, o_rdy[i], o_vld[i]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat;
    logic [31:0] d;
    logic e;
    xact(0, 1'b0, 8'd3, 32'hA5, 4'h1, lat, d, e);
    vectors++;
    if (lat !== 1 || d !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_a5 lat/data/err: got %0d %h %b, want 1 0 0", lat, d, e);
    end
    vectors++;
    if (o_vld[0] !== 1'b0 || o_rdy[0] !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_a5_post_hs vld/rdy: got %b %b, want 0 0", o_vld[0], o_rdy[0]);
    end
    @(negedge clk);
    vectors++;
    if (o_rdy[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_a5_rdy_return: got %b, want 1", o_rdy[0]);
    end
    xact(0, 1'b1, 8'd3, 32'h0, 4'h0, lat, d, e);
    vectors++;
    if (lat !== 1 || d !== 32'hA5 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_a5 lat/data/err: got %0d %h %b, want 1 a5 0", lat, d, e);
    end
    xact(0, 1'b0, 8'd4, 32'h3C, 4'h1, lat, d, e);
    vectors++;
    if (d !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_after_rd data/err: got %h %b, want 0 0", d, e);
    end
  endtask

  task automatic test_strobe();
    int lat;
    logic [31:0] d;
    logic e;
    xact(1, 1'b0, 8'd7, 32'h1122_3344, 4'hF, lat, d, e);
    xact(1, 1'b0, 8'd7, 32'hFFFF_FFFF, 4'b0101, lat, d, e);
    xact(1, 1'b1, 8'd7, 32'h0, 4'h0, lat, d, e);
    vectors++;
    if (lat !== 1 || d !== 32'h11FF_33FF || e !== 1'b0) begin
      miscompares++;
      $display("FAIL strobe_rd lat/data/err: got %0d %h %b, want 1 11ff33ff 0", lat, d, e);
    end
    xact(1, 1'b0, 8'd7, 32'h0000_0000, 4'h0, lat, d, e);
    vectors++;
    if (lat !== 1 || d !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL strobe_zero_wr lat/data/err: got %0d %h %b, want 1 0 0", lat, d, e);
    end
    xact(1, 1'b1, 8'd7, 32'h0, 4'h0, lat, d, e);
    vectors++;
    if (d !== 32'h11FF_33FF) begin
      miscompares++;
      $display("FAIL strobe_zero_rd data: got %h, want 11ff33ff", d);
    end
  endtask

  task automatic test_stall();
    int lat;
    logic [31:0] d;
    logic e;
    xact(2, 1'b0, 8'd9, 32'h5A, 4'h1, lat, d, e);
    vectors++;
    if (lat !== 4 || d !== 32'h0 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_wr lat/data/err: got %0d %h %b, want 4 0 0", lat, d, e);
    end
    rsp_rdy[2] = 1'b0;
    send(2, 1'b1, 8'd9, 32'h0, 4'h0);
    wait_rsp(2, lat);
    vectors++;
    if (lat !== 4 || o_data[2] !== 32'h5A) begin
      miscompares++;
      $display("FAIL wait_rd lat/data: got %0d %h, want 4 5a", lat, o_data[2]);
    end
    for (int k = 0; k < 5; k++) begin
      cmd_addr[2] = 8'(k);
      @(negedge clk);
      vectors++;
      if (o_vld[2] !== 1'b1 || o_data[2] !== 32'h5A || o_err[2] !== 1'b0 || o_rdy[2] !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold cyc %0d vld/data/err/rdy: got %b %h %b %b, want 1 5a 0 0",
                 k, o_vld[2], o_data[2], o_err[2], o_rdy[2]);
      end
    end
    rsp_rdy[2] = 1'b1;
    @(negedge clk);
    vectors++;
    if (o_vld[2] !== 1'b0 || o_rdy[2] !== 1'b0 || o_data[2] !== 32'h5A) begin
      miscompares++;
      $display("FAIL stall_release vld/rdy/data: got %b %b %h, want 0 0 5a",
               o_vld[2], o_rdy[2], o_data[2]);
    end
    @(negedge clk);
    vectors++;
    if (o_rdy[2] !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_rdy_return: got %b, want 1", o_rdy[2]);
    end
  endtask

  task automatic test_range();
    int lat;
    logic [31:0] d;
    logic e;
    xact(1, 1'b0, 8'd199, 32'hCAFE_F00D, 4'hF, lat, d, e);
    vectors++;
    if (lat !== 1 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL range_wr199 lat/err: got %0d %b, want 1 0", lat, e);
    end
    xact(1, 1'b0, 8'd250, 32'h1234_5678, 4'hF, lat, d, e);
    vectors++;
    if (lat !== 1 || d !== 32'h0 || e !== 1'b1) begin
      miscompares++;
      $display("FAIL range_wr250 lat/data/err: got %0d %h %b, want 1 0 1", lat, d, e);
    end
    xact(1, 1'b1, 8'd250, 32'h0, 4'h0, lat, d, e);
    vectors++;
    if (lat !== 1 || d !== 32'h0 || e !== 1'b1) begin
      miscompares++;
      $display("FAIL range_rd250 lat/data/err: got %0d %h %b, want 1 0 1", lat, d, e);
    end
    xact(1, 1'b1, 8'd199, 32'h0, 4'h0, lat, d, e);
    vectors++;
    if (d !== 32'hCAFE_F00D || e !== 1'b0) begin
      miscompares++;
      $display("FAIL range_rd199 data/err: got %h %b, want cafef00d 0", d, e);
    end
    // 250 aliases nothing in range: address 250-200=50 and 250&0x7F=122 stay unwritten,
    // so also confirm address 7 (written earlier) is untouched.
    xact(1, 1'b1, 8'd7, 32'h0, 4'h0, lat, d, e);
    vectors++;
    if (d !== 32'h11FF_33FF || e !== 1'b0) begin
      miscompares++;
      $display("FAIL range_rd7 data/err: got %h %b, want 11ff33ff 0", d, e);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] d;
    logic e;
    rsp_rdy[0] = 1'b0;
    send(0, 1'b0, 8'h40, 32'h77, 4'h1);
    wait_rsp(0, lat);
    vectors++;
    if (lat !== 1 || o_vld[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_resp lat/vld: got %0d %b, want 1 1", lat, o_vld[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (o_vld[0] !== 1'b0 || o_rdy[0] !== 1'b0 || o_data[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_async vld/rdy/data: got %b %b %h, want 0 0 0",
               o_vld[0], o_rdy[0], o_data[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    xact(0, 1'b1, 8'h40, 32'h0, 4'h0, lat, d, e);
    vectors++;
    if (lat !== 1 || d !== 32'h77 || e !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_rd lat/data/err: got %0d %h %b, want 1 77 0", lat, d, e);
    end
    xact(0, 1'b1, 8'd3, 32'h0, 4'h0, lat, d, e);
    vectors++;
    if (d !== 32'hA5) begin
      miscompares++;
      $display("FAIL rstmid_rd3 data: got %h, want a5", d);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      cmd_vld[i]  = 1'b0;
      cmd_rwb[i]  = 1'b0;
      cmd_addr[i] = 8'h00;
      cmd_wdat[i] = 32'h0;
      cmd_strb[i] = 4'h0;
      rsp_rdy[i]  = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    test_write_read();
    test_strobe();
    test_stall();
    test_range();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
